// File: rtl/keypad_code_entry.sv
// Keypad front end for digital_safe: gathers hex digits into a fixed-length code
// and handles clear, short entries, inter-key timeout and lockout from the safe.
module keypad_code_entry #(
  parameter int unsigned DIGITS         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int unsigned CW             = $clog2(DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_valid,
  input  logic [3:0]            key_value,
  input  logic                  key_enter,
  input  logic                  key_clear,
  input  logic                  lockout,
  output logic [4*DIGITS-1:0]   entered_code,
  output logic                  code_valid,
  output logic                  entry_error,
  output logic                  timeout,
  output logic [CW-1:0]         digit_count,
  output logic                  busy
);

  localparam int unsigned CODE_W = 4 * DIGITS;
  localparam int unsigned TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] FULL    = 2'd2;

  logic [1:0]        state;
  logic [CODE_W-1:0] code_buf;
  logic [TW-1:0]     idle_cnt;
  logic [CODE_W-1:0] shifted;

  // First digit ends up in the most significant nibble once the buffer fills.
  assign shifted = (code_buf << 4) | CODE_W'(key_value);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      code_buf     <= '0;
      digit_count  <= '0;
      idle_cnt     <= '0;
      entered_code <= '0;
      code_valid   <= 1'b0;
      entry_error  <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      code_valid  <= 1'b0;
      entry_error <= 1'b0;
      timeout     <= 1'b0;
      if (lockout) begin
        state       <= IDLE;
        code_buf    <= '0;
        digit_count <= '0;
        idle_cnt    <= '0;
      end else begin
        case (state)
          IDLE: begin
            idle_cnt <= '0;
            if (key_clear) begin
              state <= IDLE;
            end else if (key_enter) begin
              entry_error <= 1'b1;
            end else if (key_valid) begin
              code_buf    <= shifted;
              digit_count <= CW'(1);
              state       <= (DIGITS == 1) ? FULL : COLLECT;
            end
          end
          COLLECT, FULL: begin
            if (key_clear || key_enter) begin
              if (key_enter && !key_clear) begin
                if (state == FULL) begin
                  entered_code <= code_buf;
                  code_valid   <= 1'b1;
                end else begin
                  entry_error <= 1'b1;
                end
              end
              state       <= IDLE;
              code_buf    <= '0;
              digit_count <= '0;
              idle_cnt    <= '0;
            end else if (key_valid) begin
              // A key in the expiry cycle wins over the timeout; FULL drops the digit.
              idle_cnt <= '0;
              if (state == COLLECT) begin
                code_buf    <= shifted;
                digit_count <= digit_count + CW'(1);
                if (digit_count == CW'(DIGITS - 1))
                  state <= FULL;
              end
            end else if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
              timeout     <= 1'b1;
              state       <= IDLE;
              code_buf    <= '0;
              digit_count <= '0;
              idle_cnt    <= '0;
            end else begin
              idle_cnt <= idle_cnt + TW'(1);
            end
          end
          default: begin
            state       <= IDLE;
            code_buf    <= '0;
            digit_count <= '0;
            idle_cnt    <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_code_entry.sv
// Directed bench for keypad_code_entry with a short inter-key timeout.
module tb_keypad_code_entry;

  localparam int unsigned DIGITS = 8;
  localparam int unsigned TMO    = 16;
  localparam int unsigned CW     = $clog2(DIGITS + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              key_valid;
  logic [3:0]        key_value;
  logic              key_enter;
  logic              key_clear;
  logic              lockout;
  logic [31:0]       entered_code;
  logic              code_valid;
  logic              entry_error;
  logic              timeout;
  logic [CW-1:0]     digit_count;
  logic              busy;

  int tests = 0;
  int fails = 0;

  keypad_code_entry #(
    .DIGITS(DIGITS),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_valid(key_valid),
    .key_value(key_value),
    .key_enter(key_enter),
    .key_clear(key_clear),
    .lockout(lockout),
    .entered_code(entered_code),
    .code_valid(code_valid),
    .entry_error(entry_error),
    .timeout(timeout),
    .digit_count(digit_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Stimulus helpers: entered and left on a falling edge, one strobe cycle each.
  task automatic press_digit(input logic [3:0] v);
    key_valid = 1'b1;
    key_value = v;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic press_enter();
    key_enter = 1'b1;
    @(negedge clk);
    key_enter = 1'b0;
  endtask

  task automatic press_code(input logic [31:0] c);
    logic [31:0] t;
    t = c;
    for (int i = 7; i >= 0; i--) press_digit(t[i*4 +: 4]);
  endtask

  task automatic test_reset();
    rst = 1'b0; key_valid = 1'b0; key_value = '0; key_enter = 1'b0;
    key_clear = 1'b0; lockout = 1'b0;
    #12;
    tests++;
    if ({entered_code, code_valid, entry_error, timeout, digit_count, busy} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got code=%h cv=%b err=%b to=%b cnt=%0d busy=%b expected all 0",
               entered_code, code_valid, entry_error, timeout, digit_count, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_code();
    press_code(32'h12345678);
    tests++;
    if (digit_count !== 4'd8 || busy !== 1'b1) begin
      fails++;
      $display("FAIL full_before_enter: got cnt=%0d busy=%b expected cnt=8 busy=1", digit_count, busy);
    end
    press_enter();
    tests++;
    if (code_valid !== 1'b1 || entered_code !== 32'h12345678 || digit_count !== 4'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL full_enter: got cv=%b code=%h cnt=%0d busy=%b expected cv=1 code=12345678 cnt=0 busy=0",
               code_valid, entered_code, digit_count, busy);
    end
    @(negedge clk);
    tests++;
    if (code_valid !== 1'b0 || entered_code !== 32'h12345678) begin
      fails++;
      $display("FAIL full_pulse_width: got cv=%b code=%h expected cv=0 code=12345678", code_valid, entered_code);
    end
  endtask

  task automatic test_short_entry();
    press_digit(4'hA); press_digit(4'hB); press_digit(4'hC);
    tests++;
    if (digit_count !== 4'd3 || busy !== 1'b1) begin
      fails++;
      $display("FAIL short_count: got cnt=%0d busy=%b expected cnt=3 busy=1", digit_count, busy);
    end
    press_enter();
    tests++;
    if (entry_error !== 1'b1 || code_valid !== 1'b0 || entered_code !== 32'h12345678 || digit_count !== 4'd0) begin
      fails++;
      $display("FAIL short_enter: got err=%b cv=%b code=%h cnt=%0d expected err=1 cv=0 code=12345678 cnt=0",
               entry_error, code_valid, entered_code, digit_count);
    end
    @(negedge clk);
    tests++;
    if (entry_error !== 1'b0) begin
      fails++;
      $display("FAIL short_pulse_width: got err=%b expected 0", entry_error);
    end
    // Enter with nothing buffered is also an error.
    press_enter();
    tests++;
    if (entry_error !== 1'b1 || code_valid !== 1'b0) begin
      fails++;
      $display("FAIL empty_enter: got err=%b cv=%b expected err=1 cv=0", entry_error, code_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    press_code(32'h87654321);
    press_digit(4'h9);
    tests++;
    if (digit_count !== 4'd8) begin
      fails++;
      $display("FAIL overflow_count: got %0d expected 8", digit_count);
    end
    press_enter();
    tests++;
    if (code_valid !== 1'b1 || entered_code !== 32'h87654321) begin
      fails++;
      $display("FAIL overflow_code: got cv=%b code=%h expected cv=1 code=87654321", code_valid, entered_code);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    press_digit(4'hD); press_digit(4'hE);
    repeat (TMO - 1) @(negedge clk);
    tests++;
    if (timeout !== 1'b0 || digit_count !== 4'd2) begin
      fails++;
      $display("FAIL timeout_early: got to=%b cnt=%0d expected to=0 cnt=2", timeout, digit_count);
    end
    @(negedge clk);
    tests++;
    if (timeout !== 1'b1 || digit_count !== 4'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL timeout_fire: got to=%b cnt=%0d busy=%b expected to=1 cnt=0 busy=0", timeout, digit_count, busy);
    end
    @(negedge clk);
    tests++;
    if (timeout !== 1'b0 || entered_code !== 32'h87654321) begin
      fails++;
      $display("FAIL timeout_pulse: got to=%b code=%h expected to=0 code=87654321", timeout, entered_code);
    end
    // A key on the expiry cycle restarts the count instead.
    press_digit(4'h1);
    repeat (TMO - 1) @(negedge clk);
    press_digit(4'h2);
    tests++;
    if (timeout !== 1'b0 || digit_count !== 4'd2) begin
      fails++;
      $display("FAIL timeout_key_wins: got to=%b cnt=%0d expected to=0 cnt=2", timeout, digit_count);
    end
    // Clear and enter together: clear has priority.
    press_digit(4'h3); press_digit(4'h4);
    key_clear = 1'b1; key_enter = 1'b1;
    @(negedge clk);
    key_clear = 1'b0; key_enter = 1'b0;
    tests++;
    if (digit_count !== 4'd0 || code_valid !== 1'b0 || entry_error !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL clear_enter: got cnt=%0d cv=%b err=%b busy=%b expected 0 0 0 0",
               digit_count, code_valid, entry_error, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_lockout();
    int pulses;
    logic [31:0] c;
    pulses = 0;
    c = 32'h13572468;
    press_digit(4'h5); press_digit(4'h6);
    lockout = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      press_digit(c[i*4 +: 4]);
      pulses += int'(code_valid) + int'(entry_error) + int'(timeout);
    end
    press_enter();
    pulses += int'(code_valid) + int'(entry_error) + int'(timeout);
    repeat (2) begin
      @(negedge clk);
      pulses += int'(code_valid) + int'(entry_error) + int'(timeout);
    end
    tests++;
    if (pulses != 0 || digit_count !== 4'd0 || busy !== 1'b0 || entered_code !== 32'h87654321) begin
      fails++;
      $display("FAIL lockout_drop: got pulses=%0d cnt=%0d busy=%b code=%h expected 0 0 0 87654321",
               pulses, digit_count, busy, entered_code);
    end
    lockout = 1'b0;
    press_code(32'hAABBCCDD);
    press_enter();
    tests++;
    if (code_valid !== 1'b1 || entered_code !== 32'hAABBCCDD) begin
      fails++;
      $display("FAIL lockout_release: got cv=%b code=%h expected cv=1 code=aabbccdd", code_valid, entered_code);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) press_digit(4'h7);
    #2 rst = 1'b0;
    #1;
    tests++;
    if (digit_count !== 4'd0 || busy !== 1'b0 || entered_code !== 32'h0) begin
      fails++;
      $display("FAIL async_reset: got cnt=%0d busy=%b code=%h expected 0 0 00000000", digit_count, busy, entered_code);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (code_valid !== 1'b0 || entry_error !== 1'b0 || timeout !== 1'b0 || digit_count !== 4'd0) begin
      fails++;
      $display("FAIL post_reset_quiet: got cv=%b err=%b to=%b cnt=%0d expected all 0",
               code_valid, entry_error, timeout, digit_count);
    end
    press_code(32'h11112222);
    press_enter();
    tests++;
    if (code_valid !== 1'b1 || entered_code !== 32'h11112222) begin
      fails++;
      $display("FAIL post_reset_code: got cv=%b code=%h expected cv=1 code=11112222", code_valid, entered_code);
    end
  endtask

  task automatic test_back_to_back();
    // Next entry starts on the cycle right after the enter strobe.
    press_code(32'hDEADBEEF);
    press_enter();
    tests++;
    if (code_valid !== 1'b1 || entered_code !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL b2b_first: got cv=%b code=%h expected cv=1 code=deadbeef", code_valid, entered_code);
    end
    press_code(32'h0F1E2D3C);
    tests++;
    if (code_valid !== 1'b0 || digit_count !== 4'd8 || entered_code !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL b2b_hold: got cv=%b cnt=%0d code=%h expected cv=0 cnt=8 code=deadbeef",
               code_valid, digit_count, entered_code);
    end
    press_enter();
    tests++;
    if (code_valid !== 1'b1 || entered_code !== 32'h0F1E2D3C) begin
      fails++;
      $display("FAIL b2b_second: got cv=%b code=%h expected cv=1 code=0f1e2d3c", code_valid, entered_code);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_full_code();
    test_short_entry();
    test_overflow();
    test_timeout();
    test_lockout();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keypad_code_entry.md
Name: keypad_code_entry

Overview:
- Front-end stage that sits directly upstream of digital_safe.
- Collects debounced hex keypad strokes into a 32-bit code and presents it as `entered_code` with a one-cycle `code_valid` strobe.
- Handles the clear key, short-entry errors, inter-key timeout and a lockout input driven by the safe, so the safe only ever sees complete codes.

Parameters:
- DIGITS, 8, number of hex digits per code; entered_code width is 4*DIGITS.
- TIMEOUT_CYCLES, 50000000, idle cycles between accepted keys before a partial entry is discarded (1 s at 50 MHz).
- CW, $clog2(DIGITS+1), width of digit_count.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- key_valid  in  1  one-cycle strobe: a digit key was pressed.
- key_value  in  4  hex digit value, sampled when key_valid=1.
- key_enter  in  1  one-cycle strobe: submit key.
- key_clear  in  1  one-cycle strobe: clear key.
- lockout  in  1  safe is locked out; while high, all keys are ignored.
- entered_code  out  4*DIGITS  last submitted code, held until the next submission.
- code_valid  out  1  one-cycle pulse when entered_code updates.
- entry_error  out  1  one-cycle pulse when enter is pressed with fewer than DIGITS digits.
- timeout  out  1  one-cycle pulse when a partial entry expires.
- digit_count  out  CW  number of digits currently buffered.
- busy  out  1  high while state is COLLECT or FULL.

Behaviour:
- Reset (rst=0, asynchronous):
  - entered_code, shift buffer, digit_count, idle counter = 0.
  - code_valid, entry_error, timeout, busy = 0.
  - state = IDLE.
- States: IDLE, COLLECT, FULL.
- Input priority per cycle: lockout > key_clear > key_enter > key_valid. At most one input action is taken per cycle.
- Digit shift: buffer <= {buffer[4*DIGITS-5:0], key_value}, so the first digit lands in the MSB nibble after DIGITS keys. digit_count increments by 1.
- IDLE:
  - key_valid: shift digit, count=1, go to COLLECT.
  - key_enter with count=0: pulse entry_error.
  - key_clear: no effect.
- COLLECT:
  - key_valid: shift digit. If the count reaches DIGITS, go to FULL.
  - key_enter: pulse entry_error, clear buffer/count, go to IDLE. entered_code is unchanged.
- FULL:
  - key_valid: ignored; no shift, count stays at DIGITS.
  - key_enter: entered_code <= buffer, pulse code_valid, clear buffer/count, go to IDLE.
- Clear and lockout:
  - key_clear in COLLECT/FULL: clear buffer/count, go to IDLE. No pulse.
  - lockout=1 in any state: clear buffer/count, go to IDLE, hold idle counter at 0. Keys arriving during lockout are dropped and no pulses are emitted.
- Latency: all outputs are registered. code_valid, entry_error and timeout assert in the cycle after the strobe is sampled, for exactly one cycle. entered_code is stable in the same cycle code_valid is high.
- Timeout counter:
  - Runs only in COLLECT/FULL; reset to 0 on every accepted key and on entry to IDLE.
  - When it reaches TIMEOUT_CYCLES-1 with no input: pulse timeout, clear buffer/count, go to IDLE.
  - A key arriving in that same cycle takes precedence and resets the counter; no timeout is issued.
- Reset asserted mid-entry: buffer and outputs clear immediately; no pulse is emitted after reset releases.
- entered_code is never altered by clear, timeout, error or lockout.

Test Plan:
- Keys 1,2,3,4,5,6,7,8 then enter -> next cycle code_valid=1 for 1 cycle, entered_code=32'h12345678, digit_count=0, busy=0.
- Keys A,B,C then enter -> entry_error 1-cycle pulse, code_valid stays 0, entered_code retains 32'h12345678, digit_count=0.
- Keys 8,7,6,5,4,3,2,1,9 then enter -> ninth key ignored (digit_count stays 8), entered_code=32'h87654321.
- Bench parameter TIMEOUT_CYCLES=16: keys D,E then 16 idle cycles -> timeout 1-cycle pulse, digit_count=0; same run with key_clear and key_enter in one cycle after 4 digits -> buffer cleared, no code_valid.
- lockout=1 while sending 8 digits + enter -> no pulses, digit_count=0; release lockout, enter 8 digits of AABBCCDD + enter -> entered_code=32'hAABBCCDD.
- rst=0 after 5 digits -> digit_count=0 and busy=0 immediately (asynchronous); after release, a full entry 11112222 + enter -> code_valid, entered_code=32'h11112222.
